// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with two-word instruction assembly,
//               branch redirect, RET/RTI PC pop and interrupt entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INT_VEC  = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        fetch_pc_enable,
    input  logic        branch_taken,
    input  logic [31:0] pc_jmp,
    input  logic        freeze,
    input  logic        pop_pc1,
    input  logic        pop_pc2,
    input  logic [15:0] mem_rdata,
    input  logic        interrupt,
    output logic        int_ack,
    output logic [31:0] int_ret_pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_imm,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_IMM2     = 2'd1;
    localparam logic [1:0] S_RET_WAIT = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [15:0] r_buffer;
    logic [15:0] r_pc_hi;
    logic        r_int_pending;
    logic        r_int_ack;
    logic [31:0] r_int_ret_pc;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_imm;
    logic [31:0] r_if_pc;
    logic        r_if_valid;

    logic [31:0] w_pc_inc;
    logic        w_two_word;
    logic        w_hold;
    logic        w_in_ret;
    logic        w_int_entry;

    assign w_pc_inc   = r_pc + 32'd1;
    assign w_two_word = (imem_data[15:11] == 5'b11000) ||
                        (imem_data[15:11] == 5'b11001) ||
                        (imem_data[15:11] == 5'b11010);
    assign w_hold     = stall | ~fetch_pc_enable;
    assign w_in_ret   = (r_state == S_RET_WAIT);
    // Interrupts are only taken on a clean RUN edge so no instruction is split.
    assign w_int_entry = (r_state == S_RUN) & r_int_pending & ~w_hold &
                         ~branch_taken & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_buffer      <= 16'h0000;
            r_pc_hi       <= 16'h0000;
            r_int_pending <= 1'b0;
            r_int_ack     <= 1'b0;
            r_int_ret_pc  <= 32'h0000_0000;
            r_if_instr    <= 16'h0000;
            r_if_imm      <= 16'h0000;
            r_if_pc       <= 32'h0000_0000;
            r_if_valid    <= 1'b0;
        end else begin
            r_int_ack <= 1'b0;

            if (w_int_entry) begin
                r_int_pending <= 1'b0;
            end else if (interrupt) begin
                r_int_pending <= 1'b1;
            end

            if (w_in_ret && pop_pc1) begin
                r_pc_hi <= mem_rdata;
            end

            if (w_in_ret && pop_pc2) begin
                r_pc       <= {r_pc_hi, mem_rdata};
                r_state    <= S_RUN;
                r_if_instr <= 16'h0000;
                r_if_imm   <= 16'h0000;
                r_if_valid <= 1'b0;
            end else if (branch_taken) begin
                r_pc       <= pc_jmp;
                r_state    <= S_RUN;
                r_if_instr <= 16'h0000;
                r_if_imm   <= 16'h0000;
                r_if_valid <= 1'b0;
            end else if (freeze) begin
                r_state    <= S_RET_WAIT;
                r_if_instr <= 16'h0000;
                r_if_imm   <= 16'h0000;
                r_if_valid <= 1'b0;
            end else if (w_hold) begin
                r_state <= r_state;
            end else if (w_int_entry) begin
                r_int_ack    <= 1'b1;
                r_int_ret_pc <= r_pc;
                r_pc         <= INT_VEC;
                r_if_instr   <= 16'h0000;
                r_if_imm     <= 16'h0000;
                r_if_valid   <= 1'b0;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_pc <= w_pc_inc;
                        if (w_two_word) begin
                            r_buffer   <= imem_data;
                            r_if_instr <= 16'h0000;
                            r_if_imm   <= 16'h0000;
                            r_if_valid <= 1'b0;
                            r_state    <= S_IMM2;
                        end else begin
                            r_if_instr <= imem_data;
                            r_if_imm   <= 16'h0000;
                            r_if_pc    <= w_pc_inc;
                            r_if_valid <= 1'b1;
                        end
                    end
                    S_IMM2: begin
                        r_if_instr <= r_buffer;
                        r_if_imm   <= imem_data;
                        r_if_pc    <= w_pc_inc;
                        r_if_valid <= 1'b1;
                        r_pc       <= w_pc_inc;
                        r_state    <= S_RUN;
                    end
                    default: begin
                        r_if_instr <= 16'h0000;
                        r_if_imm   <= 16'h0000;
                        r_if_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem_addr  = r_pc;
    assign int_ack    = r_int_ack;
    assign int_ret_pc = r_int_ret_pc;
    assign if_instr   = r_if_instr;
    assign if_imm     = r_if_imm;
    assign if_pc      = r_if_pc;
    assign if_valid   = r_if_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed vector bench for fetch_unit with a small instruction
//               memory model and hand-written reset/wrap/interrupt sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall, fetch_pc_enable, branch_taken, freeze;
    logic [31:0] pc_jmp;
    logic        pop_pc1, pop_pc2, interrupt;
    logic [15:0] mem_rdata;
    logic        int_ack;
    logic [31:0] int_ret_pc;
    logic [15:0] if_instr, if_imm;
    logic [31:0] if_pc;
    logic        if_valid;

    logic [15:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign imem_data = mem[imem_addr[7:0]];

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .fetch_pc_enable(fetch_pc_enable),
        .branch_taken(branch_taken), .pc_jmp(pc_jmp), .freeze(freeze),
        .pop_pc1(pop_pc1), .pop_pc2(pop_pc2), .mem_rdata(mem_rdata),
        .interrupt(interrupt), .int_ack(int_ack), .int_ret_pc(int_ret_pc),
        .if_instr(if_instr), .if_imm(if_imm), .if_pc(if_pc), .if_valid(if_valid)
    );

    typedef struct {
        logic        stall;
        logic        fen;
        logic        br;
        logic [31:0] jmp;
        logic        frz;
        logic        p1;
        logic        p2;
        logic [15:0] rdata;
        logic        irq;
        logic [15:0] e_instr;
        logic [15:0] e_imm;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_addr;
        logic        e_ack;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] j,
                         input logic z, input logic q1, input logic q2,
                         input logic [15:0] rd, input logic irq);
        stall = s; fetch_pc_enable = f; branch_taken = b; pc_jmp = j;
        freeze = z; pop_pc1 = q1; pop_pc2 = q2; mem_rdata = rd; interrupt = irq;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0800; mem[1] = 16'h1000; mem[2] = 16'h2000; mem[3] = 16'h3000;
        mem[4] = 16'hC001; mem[5] = 16'h1234; mem[6] = 16'h4000; mem[7] = 16'h5000;
        mem[8'h40] = 16'h8000; mem[8'h10] = 16'h9000; mem[8'h11] = 16'hA000;
        mem[8'hFF] = 16'h1111;

        //            stall fen br jmp       frz p1 p2 rdata     irq  instr     imm       pc            v  addr          ack ret
        vecs[0]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0800,16'h0,   32'h1,      1'b1,32'h1,      1'b0,32'h0};
        vecs[1]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h1000,16'h0,   32'h2,      1'b1,32'h2,      1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h2000,16'h0,   32'h3,      1'b1,32'h3,      1'b0,32'h0};
        vecs[3]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h3000,16'h0,   32'h4,      1'b1,32'h4,      1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h5,      1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'hC001,16'h1234,32'h6,      1'b1,32'h6,      1'b0,32'h0};
        vecs[6]  = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h4000,16'h0,   32'h7,      1'b1,32'h7,      1'b0,32'h0};
        vecs[7]  = '{1'b1,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h4000,16'h0,   32'h7,      1'b1,32'h7,      1'b0,32'h0};
        vecs[8]  = '{1'b1,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h4000,16'h0,   32'h7,      1'b1,32'h7,      1'b0,32'h0};
        vecs[9]  = '{1'b1,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h4000,16'h0,   32'h7,      1'b1,32'h7,      1'b0,32'h0};
        vecs[10] = '{1'b1,1'b1,1'b1,32'h40,  1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h40,     1'b0,32'h0};
        vecs[11] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h8000,16'h0,   32'h41,     1'b1,32'h41,     1'b0,32'h0};
        vecs[12] = '{1'b0,1'b0,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h8000,16'h0,   32'h41,     1'b1,32'h41,     1'b0,32'h0};
        vecs[13] = '{1'b0,1'b1,1'b1,32'h9,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h9,      1'b0,32'h0};
        vecs[14] = '{1'b0,1'b1,1'b0,32'h0,   1'b1,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h9,      1'b0,32'h0};
        vecs[15] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h9,      1'b0,32'h0};
        vecs[16] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b1,1'b0,16'h0001,1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h9,      1'b0,32'h0};
        vecs[17] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h9,      1'b0,32'h0};
        vecs[18] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b1,16'h0010,1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h10010,  1'b0,32'h0};
        vecs[19] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h9000,16'h0,   32'h10011,  1'b1,32'h10011,  1'b0,32'h0};
        vecs[20] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b1,16'hFFFF,1'b0,16'hA000,16'h0,   32'h10012,  1'b1,32'h10012,  1'b0,32'h0};
        vecs[21] = '{1'b0,1'b1,1'b1,32'h4,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h4,      1'b0,32'h0};
        vecs[22] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h5,      1'b0,32'h0};
        vecs[23] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b1,16'hC001,16'h1234,32'h6,      1'b1,32'h6,      1'b0,32'h0};
        vecs[24] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h0000,16'h0,   32'h0,      1'b0,32'h2,      1'b1,32'h6};
        vecs[25] = '{1'b0,1'b1,1'b0,32'h0,   1'b0,1'b0,1'b0,16'h0,   1'b0,16'h2000,16'h0,   32'h3,      1'b1,32'h3,      1'b0,32'h6};

        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        step();
        check("reset addr", imem_addr, 32'h0);
        check("reset valid", {31'b0, if_valid}, 32'h0);
        check("reset instr", {16'b0, if_instr}, 32'h0);
        check("reset ack", {31'b0, int_ack}, 32'h0);
        check("reset ret", int_ret_pc, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            drive(vecs[i].stall, vecs[i].fen, vecs[i].br, vecs[i].jmp, vecs[i].frz,
                  vecs[i].p1, vecs[i].p2, vecs[i].rdata, vecs[i].irq);
            step();
            check($sformatf("v%0d instr", i), {16'b0, if_instr}, {16'b0, vecs[i].e_instr});
            check($sformatf("v%0d valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d ack", i), {31'b0, int_ack}, {31'b0, vecs[i].e_ack});
            check($sformatf("v%0d ret", i), int_ret_pc, vecs[i].e_ret);
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d imm", i), {16'b0, if_imm}, {16'b0, vecs[i].e_imm});
                check($sformatf("v%0d if_pc", i), if_pc, vecs[i].e_pc);
            end
        end

        // Reset in the middle of a two-word fetch with an interrupt pending.
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check("seq1 fetch3", {16'b0, if_instr}, 32'h3000);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        step();
        check("seq1 bubble", {31'b0, if_valid}, 32'h0);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check("seq1 rst addr", imem_addr, 32'h0);
        check("seq1 rst ret", int_ret_pc, 32'h0);
        rst = 1'b0;
        step();
        check("seq1 instr0", {16'b0, if_instr}, 32'h0800);
        check("seq1 ack0", {31'b0, int_ack}, 32'h0);
        step();
        check("seq1 instr1", {16'b0, if_instr}, 32'h1000);
        check("seq1 ack1", {31'b0, int_ack}, 32'h0);

        // PC wraps from all-ones to zero.
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check("wrap addr", imem_addr, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check("wrap instr", {16'b0, if_instr}, 32'h1111);
        check("wrap if_pc", if_pc, 32'h0);
        check("wrap next", imem_addr, 32'h0);

        // Two requests during a stall merge into a single deferred entry.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        step();
        check("seq3 stall ack a", {31'b0, int_ack}, 32'h0);
        step();
        check("seq3 stall ack b", {31'b0, int_ack}, 32'h0);
        check("seq3 stall addr", imem_addr, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        check("seq3 ack", {31'b0, int_ack}, 32'h1);
        check("seq3 ret", int_ret_pc, 32'h0);
        check("seq3 vec", imem_addr, 32'h2);
        step();
        check("seq3 ack low", {31'b0, int_ack}, 32'h0);
        check("seq3 instr", {16'b0, if_instr}, 32'h2000);
        step();
        check("seq3 no reentry", {31'b0, int_ack}, 32'h0);
        check("seq3 addr", imem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
